// File: rtl/kamus_lsu_ctrl.sv
// kamus_lsu_ctrl: load/store unit controller between the execute stage and the L1D port
module kamus_lsu_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o,
  output logic        bus_err_o
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE, ERR} state_t;
  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);
  state_t state;
  logic we_q, uns_q, mis_q;
  logic [1:0] size_q, off_q;
  logic [7:0] cnt, cnt_inc;
  logic misaligned, accept, timeout;
  logic [3:0] be_n;
  logic [31:0] wdata_n, shifted, ext;
  assign misaligned = (req_size_i == 2'b11) || (req_size_i == 2'b01 && req_addr_i[0]) ||
                      (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
  assign accept = state == IDLE && req_valid_i && !flush_i;
  assign be_n = req_size_i == 2'b00 ? 4'b0001 << req_addr_i[1:0] :
                req_size_i == 2'b01 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
  assign wdata_n = req_size_i == 2'b00 ? {4{req_wdata_i[7:0]}} :
                   req_size_i == 2'b01 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  assign shifted = mem_rdata_i >> {off_q, 3'b000};
  assign ext = size_q == 2'b00 ? {{24{~uns_q & shifted[7]}}, shifted[7:0]} :
               size_q == 2'b01 ? {{16{~uns_q & shifted[15]}}, shifted[15:0]} : shifted;
  // saturating so a long wait can never wrap back below the limit
  assign cnt_inc = cnt == 8'hFF ? cnt : cnt + 8'd1;
  assign timeout = cnt_inc >= TMO;
  assign mem_req_o = state == REQ;
  assign mem_we_o = state == REQ && we_q;
  assign stall_o = accept || state inside {REQ, WAIT, DRAIN};
  assign done_o = state inside {DONE, ERR};
  assign misaligned_o = state == ERR && mis_q;
  assign bus_err_o = state == ERR && !mis_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      we_q <= 1'b0;
      uns_q <= 1'b0;
      mis_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
      cnt <= '0;
      mem_addr_o <= '0;
      mem_be_o <= '0;
      mem_wdata_o <= '0;
      rdata_o <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (misaligned) begin
            mis_q <= 1'b1;
            state <= ERR;
          end else begin
            we_q <= req_we_i;
            size_q <= req_size_i;
            uns_q <= req_unsigned_i;
            off_q <= req_addr_i[1:0];
            mem_addr_o <= {req_addr_i[31:2], 2'b00};
            mem_be_o <= be_n;
            mem_wdata_o <= wdata_n;
            state <= REQ;
          end
        end
        REQ: if (mem_gnt_i) begin
          cnt <= '0;
          state <= flush_i ? (we_q ? IDLE : DRAIN) : (we_q ? DONE : WAIT);
        end else if (flush_i) state <= IDLE;
        WAIT: if (mem_rvalid_i) begin
          if (!flush_i) rdata_o <= ext;
          state <= flush_i ? IDLE : DONE;
        end else if (flush_i) begin
          cnt <= '0;
          state <= DRAIN;
        end else if (timeout) begin
          mis_q <= 1'b0;
          state <= ERR;
        end else cnt <= cnt_inc;
        DRAIN: if (mem_rvalid_i || timeout) state <= IDLE;
               else cnt <= cnt_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
